// File: rtl/rvc_asap_dmem_fabric_5pl.sv
// Q103H data-access interconnect: decodes to NUM_TGT targets, inserts ready-based wait states with timeout,
// and returns aligned/extended load data at Q104H. Optional counters via RVC_DMEM_FABRIC_PERF_EN.
module rvc_asap_dmem_fabric_5pl #(
    parameter int NUM_TGT = 4,
    parameter int DEC_LSB = 12,
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 15
) (
    input  logic                   Clock,
    input  logic                   Rst,
    input  logic [31:0]            AddrQ103H,
    input  logic [31:0]            WrDataQ103H,
    input  logic [3:0]             ByteEnQ103H,
    input  logic                   WrEnQ103H,
    input  logic                   RdEnQ103H,
    input  logic                   SignExtQ103H,
    output logic                   StallQ103H,
    output logic [31:0]            RdDataQ104H,
    output logic                   ErrQ104H,
    output logic [NUM_TGT-1:0]     TgtReq,
    output logic                   TgtWrEn,
    output logic [31:0]            TgtAddr,
    output logic [31:0]            TgtWrData,
    output logic [3:0]             TgtByteEn,
    input  logic [NUM_TGT-1:0]     TgtReady,
    input  logic [NUM_TGT*32-1:0]  TgtRdData
`ifdef RVC_DMEM_FABRIC_PERF_EN
    ,
    output logic [NUM_TGT*32-1:0]  PerfAccCnt,
    output logic [31:0]            PerfStallCnt
`endif
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [IDX_W:0] NUM_TGT_V = (IDX_W+1)'(NUM_TGT);
    localparam logic [7:0]     TIMEOUT_V = 8'(TIMEOUT);

    state_t             state;
    logic [7:0]         wait_cnt;
    logic [IDX_W-1:0]   idx;
    logic [NUM_TGT-1:0] sel;
    logic               access;
    logic               load;
    logic               idx_ok;
    logic               rdy_sel;
    logic               abort;
    logic               req_on;
    logic               accept;
    logic               dec_err;

    // Q104H sideband captured on acceptance
    logic [IDX_W-1:0]   idx_q;
    logic [1:0]         lo_q;
    logic [3:0]         be_q;
    logic               sext_q;
    logic               ld_q;
    logic               err_q;

    logic [31:0]        word;
    logic [15:0]        half;
    logic [7:0]         byte_v;

    assign idx    = AddrQ103H[DEC_LSB+IDX_W-1:DEC_LSB];
    assign access = RdEnQ103H | WrEnQ103H;
    assign load   = RdEnQ103H & ~WrEnQ103H;
    assign idx_ok = {1'b0, idx} < NUM_TGT_V;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            sel[i] = ({1'b0, idx} == (IDX_W+1)'(i));
        end
    end

    assign rdy_sel = |(sel & TgtReady);
    // Inputs are held stable during WAIT, so the request decode stays valid until accept or abort.
    assign abort   = ~Rst & access & idx_ok & ~rdy_sel & (state == WAIT) & (wait_cnt == TIMEOUT_V);
    assign req_on  = ~Rst & access & idx_ok & ~abort;
    assign accept  = req_on & rdy_sel;
    assign dec_err = ~Rst & access & ~idx_ok;

    assign TgtReq     = req_on ? sel : '0;
    assign StallQ103H = req_on & ~rdy_sel;
    assign TgtWrEn    = WrEnQ103H;
    assign TgtAddr    = AddrQ103H;
    assign TgtWrData  = WrDataQ103H;
    assign TgtByteEn  = ByteEnQ103H;

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            idx_q    <= '0;
            lo_q     <= '0;
            be_q     <= '0;
            sext_q   <= 1'b0;
            ld_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= dec_err | abort;
            ld_q  <= accept & load;
            if (accept) begin
                idx_q  <= idx;
                lo_q   <= AddrQ103H[1:0];
                be_q   <= ByteEnQ103H;
                sext_q <= SignExtQ103H;
            end
            case (state)
                IDLE: begin
                    if (req_on && !rdy_sel) begin
                        state    <= WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                WAIT: begin
                    if (!req_on || rdy_sel) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        word = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (idx_q == IDX_W'(i)) begin
                word = TgtRdData[i*32 +: 32];
            end
        end
    end

    always_comb begin
        half        = lo_q[1] ? word[31:16] : word[15:0];
        byte_v      = word[7:0];
        RdDataQ104H = '0;
        case (lo_q)
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        if (ld_q) begin
            case (be_q)
                4'hF:       RdDataQ104H = word;
                4'h3, 4'hC: RdDataQ104H = {{16{sext_q & half[15]}}, half};
                default:    RdDataQ104H = {{24{sext_q & byte_v[7]}}, byte_v};
            endcase
        end
    end

    assign ErrQ104H = err_q;

`ifdef RVC_DMEM_FABRIC_PERF_EN
    always_ff @(posedge Clock) begin
        if (Rst) begin
            PerfAccCnt   <= '0;
            PerfStallCnt <= '0;
        end else begin
            for (int i = 0; i < NUM_TGT; i++) begin
                if (accept && sel[i] && (PerfAccCnt[i*32 +: 32] != 32'hFFFF_FFFF)) begin
                    PerfAccCnt[i*32 +: 32] <= PerfAccCnt[i*32 +: 32] + 32'd1;
                end
            end
            if (StallQ103H && (PerfStallCnt != 32'hFFFF_FFFF)) begin
                PerfStallCnt <= PerfStallCnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rvc_asap_dmem_fabric_5pl.sv
// Directed bench for rvc_asap_dmem_fabric_5pl with a cycle-level reference model and literal spot checks.
module tb_rvc_asap_dmem_fabric_5pl;

    localparam int NT = 4;
    localparam int TO = 15;

    logic              Clock = 1'b0;
    logic              Rst;
    logic [31:0]       AddrQ103H;
    logic [31:0]       WrDataQ103H;
    logic [3:0]        ByteEnQ103H;
    logic              WrEnQ103H;
    logic              RdEnQ103H;
    logic              SignExtQ103H;
    logic              StallQ103H;
    logic [31:0]       RdDataQ104H;
    logic              ErrQ104H;
    logic [NT-1:0]     TgtReq;
    logic              TgtWrEn;
    logic [31:0]       TgtAddr;
    logic [31:0]       TgtWrData;
    logic [3:0]        TgtByteEn;
    logic [NT-1:0]     TgtReady;
    logic [NT*32-1:0]  TgtRdData;
    logic [31:0]       tgt_data [NT];
`ifdef RVC_DMEM_FABRIC_PERF_EN
    logic [NT*32-1:0]  PerfAccCnt;
    logic [31:0]       PerfStallCnt;
`endif

    int checks = 0;
    int errors = 0;

    rvc_asap_dmem_fabric_5pl #(.NUM_TGT(NT), .DEC_LSB(12), .IDX_W(3), .TIMEOUT(TO)) dut (
        .Clock(Clock), .Rst(Rst),
        .AddrQ103H(AddrQ103H), .WrDataQ103H(WrDataQ103H), .ByteEnQ103H(ByteEnQ103H),
        .WrEnQ103H(WrEnQ103H), .RdEnQ103H(RdEnQ103H), .SignExtQ103H(SignExtQ103H),
        .StallQ103H(StallQ103H), .RdDataQ104H(RdDataQ104H), .ErrQ104H(ErrQ104H),
        .TgtReq(TgtReq), .TgtWrEn(TgtWrEn), .TgtAddr(TgtAddr), .TgtWrData(TgtWrData),
        .TgtByteEn(TgtByteEn), .TgtReady(TgtReady), .TgtRdData(TgtRdData)
`ifdef RVC_DMEM_FABRIC_PERF_EN
        , .PerfAccCnt(PerfAccCnt), .PerfStallCnt(PerfStallCnt)
`endif
    );

    always #5 Clock = ~Clock;

    always_comb begin
        TgtRdData = '0;
        for (int i = 0; i < NT; i++) TgtRdData[i*32 +: 32] = tgt_data[i];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lo,
                                            input logic [3:0] be, input logic sx);
        logic [31:0] sh;
        if (be == 4'hF) return w;
        if (be == 4'h3 || be == 4'hC) begin
            sh = w >> (16 * lo[1]);
            return sx ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
        end
        sh = w >> (8 * lo);
        return sx ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
    endfunction

    // Reference model: a pending access waits up to TO cycles; results appear one cycle later.
    logic        m_err = 1'b0;
    logic        m_ld  = 1'b0;
    int          m_idx = 0;
    logic [1:0]  m_lo  = '0;
    logic [3:0]  m_be  = '0;
    logic        m_sx  = 1'b0;
    int          pend  = 0;

    always @(negedge Clock) begin : model
        logic [31:0] e_rd;
        logic [3:0]  e_req;
        logic        e_stall;
        int          idx;
        e_rd = m_ld ? extract(TgtRdData[m_idx*32 +: 32], m_lo, m_be, m_sx) : 32'h0;
        chk("m_err", 32'(ErrQ104H), 32'(m_err));
        chk("m_rdata", RdDataQ104H, e_rd);
        idx     = int'(AddrQ103H[14:12]);
        e_req   = '0;
        e_stall = 1'b0;
        m_err   = 1'b0;
        m_ld    = 1'b0;
        if (Rst || !(RdEnQ103H || WrEnQ103H)) begin
            pend = 0;
        end else if (idx >= NT) begin
            m_err = 1'b1;
            pend  = 0;
        end else if (TgtReady[idx]) begin
            e_req = 4'(1 << idx);
            m_ld  = RdEnQ103H && !WrEnQ103H;
            m_idx = idx;
            m_lo  = AddrQ103H[1:0];
            m_be  = ByteEnQ103H;
            m_sx  = SignExtQ103H;
            pend  = 0;
        end else if (pend == TO) begin
            m_err = 1'b1;
            pend  = 0;
        end else begin
            e_req   = 4'(1 << idx);
            e_stall = 1'b1;
            pend++;
        end
        chk("m_req", 32'(TgtReq), 32'(e_req));
        chk("m_stall", 32'(StallQ103H), 32'(e_stall));
        if (e_req != 0) begin
            chk("m_addr", TgtAddr, AddrQ103H);
            chk("m_wdata", TgtWrData, WrDataQ103H);
            chk("m_be", 32'(TgtByteEn), 32'(ByteEnQ103H));
            chk("m_wren", 32'(TgtWrEn), 32'(WrEnQ103H));
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be, input logic sx);
        RdEnQ103H    = rd;
        WrEnQ103H    = wr;
        AddrQ103H    = addr;
        WrDataQ103H  = wd;
        ByteEnQ103H  = be;
        SignExtQ103H = sx;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_n;
        int req_n;
        int acc_n;
        Rst = 1'b1;
        idle();
        TgtReady = '1;
        for (int i = 0; i < NT; i++) tgt_data[i] = 32'h0;

        @(negedge Clock);
        chk("rst_stall", 32'(StallQ103H), 32'h0);
        chk("rst_req", 32'(TgtReq), 32'h0);
        chk("rst_err", 32'(ErrQ104H), 32'h0);
        chk("rst_rdata", RdDataQ104H, 32'h0);
        step();
        Rst = 1'b0;

        // Word load to target 1
        tgt_data[1] = 32'hDEAD_BEEF;
        drive(1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'hF, 1'b0);
        @(negedge Clock);
        chk("lw_req", 32'(TgtReq), 32'h2);
        chk("lw_stall", 32'(StallQ103H), 32'h0);
        step();
        idle();
        @(negedge Clock);
        chk("lw_rdata", RdDataQ104H, 32'hDEAD_BEEF);
        step();

        // Byte and half loads, back to back
        tgt_data[0] = 32'h80FF_FFFF;
        drive(1'b1, 1'b0, 32'h0000_0003, 32'h0, 4'b1000, 1'b1);
        @(negedge Clock);
        step();
        drive(1'b1, 1'b0, 32'h0000_0003, 32'h0, 4'b1000, 1'b0);
        @(negedge Clock);
        chk("lb_sext", RdDataQ104H, 32'hFFFF_FF80);
        step();
        drive(1'b1, 1'b0, 32'h0000_0002, 32'h0, 4'b1100, 1'b1);
        @(negedge Clock);
        chk("lbu_zext", RdDataQ104H, 32'h0000_0080);
        step();
        idle();
        @(negedge Clock);
        chk("lh_sext", RdDataQ104H, 32'hFFFF_80FF);
        step();

        // Store to target 2 with three wait cycles
        stall_n = 0; req_n = 0; acc_n = 0;
        drive(1'b0, 1'b1, 32'h0000_2000, 32'h1234_5678, 4'hF, 1'b0);
        for (int k = 0; k < 4; k++) begin
            TgtReady[2] = (k == 3);
            @(negedge Clock);
            if (StallQ103H) stall_n++;
            if (TgtReq == 4'b0100) req_n++;
            if (TgtReq[2] && TgtReady[2]) acc_n++;
            step();
        end
        idle();
        TgtReady = '1;
        @(negedge Clock);
        chk("st_rdata", RdDataQ104H, 32'h0);
        chk("st_err", 32'(ErrQ104H), 32'h0);
        chk("st_stall_cycles", 32'(stall_n), 32'd3);
        chk("st_req_cycles", 32'(req_n), 32'd4);
        chk("st_accepts", 32'(acc_n), 32'd1);
        step();

        // Decode error
        drive(1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'hF, 1'b0);
        @(negedge Clock);
        chk("dec_req", 32'(TgtReq), 32'h0);
        chk("dec_stall", 32'(StallQ103H), 32'h0);
        step();
        idle();
        @(negedge Clock);
        chk("dec_err", 32'(ErrQ104H), 32'h1);
        chk("dec_rdata", RdDataQ104H, 32'h0);
        step();
        @(negedge Clock);
        chk("dec_err_once", 32'(ErrQ104H), 32'h0);
        step();

        // Timeout on target 3
        TgtReady[3] = 1'b0;
        tgt_data[3] = 32'hCAFE_F00D;
        stall_n = 0;
        drive(1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'hF, 1'b0);
        for (int c = 0; c < 40; c++) begin
            @(negedge Clock);
            if (!StallQ103H) break;
            stall_n++;
            step();
        end
        chk("to_abort_req", 32'(TgtReq), 32'h0);
        chk("to_stall_cycles", 32'(stall_n), 32'd15);
        step();
        idle();
        @(negedge Clock);
        chk("to_err", 32'(ErrQ104H), 32'h1);
        chk("to_rdata", RdDataQ104H, 32'h0);
        step();
        @(negedge Clock);
        chk("to_err_once", 32'(ErrQ104H), 32'h0);
        step();

        // Reset during a stall
        drive(1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'hF, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge Clock);
            step();
        end
        @(negedge Clock);
        chk("rw_stall_before", 32'(StallQ103H), 32'h1);
        step();
        Rst = 1'b1;
        @(negedge Clock);
        chk("rw_stall_in_rst", 32'(StallQ103H), 32'h0);
        chk("rw_req_in_rst", 32'(TgtReq), 32'h0);
        step();
        Rst = 1'b0;
        idle();
        @(negedge Clock);
        chk("rw_no_err", 32'(ErrQ104H), 32'h0);
        step();
        @(negedge Clock);
        chk("rw_no_err2", 32'(ErrQ104H), 32'h0);
        TgtReady = '1;
        step();
        drive(1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'hF, 1'b0);
        @(negedge Clock);
        chk("rw_fresh_req", 32'(TgtReq), 32'h8);
        chk("rw_fresh_stall", 32'(StallQ103H), 32'h0);
        step();
        idle();
        @(negedge Clock);
        chk("rw_fresh_rdata", RdDataQ104H, 32'hCAFE_F00D);
        step();

`ifdef RVC_DMEM_FABRIC_PERF_EN
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'hF, 1'b0);
            step();
        end
        for (int k = 0; k < 5; k++) begin
            TgtReady[0] = (k == 4);
            step();
        end
        idle();
        TgtReady = '1;
        @(negedge Clock);
        chk("perf_acc0", PerfAccCnt[31:0], 32'd10);
        chk("perf_acc1", PerfAccCnt[63:32], 32'd0);
        chk("perf_stall", PerfStallCnt, 32'd4);
        step();
`endif

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
